// File: rtl/cylon_mode_ctrl.sv
// cylon_mode_ctrl: button/switch front-end for the cylon LED engine.
// Synchronises and debounces the three mode buttons, arbitrates simultaneous
// presses (C > R > L), and defers each mode change to the next engine step
// boundary. A timeout forces the change through if the engine stops stepping.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   btn_c/l/r     raw buttons requesting CYLON (00) / R_TO_L (01) / L_TO_R (10)
//   sw[3:0]       raw switches: sw[2:0] speed, sw[3] brightness MSB
//   step          one-cycle pulse from the engine at each LED position change
//   mode          current mode to the engine
//   speed         {1'b0, sw[2:0]} sampled on step
//   brightness    {sw[3], 3'b111} sampled on step
//   pending       high while a mode change waits for a step boundary
//   mode_changed  one-cycle pulse in the cycle mode takes a new value
module cylon_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned STEP_TIMEOUT    = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic [3:0] sw,
    input  logic       step,
    output logic [1:0] mode,
    output logic [3:0] speed,
    output logic [3:0] brightness,
    output logic       pending,
    output logic       mode_changed
);

    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TOW = (STEP_TIMEOUT > 1) ? $clog2(STEP_TIMEOUT) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(STEP_TIMEOUT - 1);

    localparam logic [1:0] MODE_CYLON  = 2'b00;
    localparam logic [1:0] MODE_R_TO_L = 2'b01;
    localparam logic [1:0] MODE_L_TO_R = 2'b10;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // Button vector index: 0 = centre, 1 = left, 2 = right
    logic [2:0]     btn_raw;
    logic [2:0]     btn_s1, btn_s2;
    logic [3:0]     sw_s1, sw_s2;
    logic [2:0]     btn_db;
    logic [2:0]     press;
    logic [DBW-1:0] db_cnt [3];

    assign btn_raw = {btn_r, btn_l, btn_c};

    // Two-flop synchronisers for buttons and switches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    // Debounce: level accepted after DEBOUNCE_CYCLES consecutive differing cycles;
    // press is registered so it lines up with the first cycle of the new level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= '0;
            press  <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (btn_s2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_db[i] <= btn_s2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= btn_s2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Press arbitration: centre beats right beats left
    logic       ev_c;
    logic [1:0] req_c;

    always_comb begin
        ev_c  = |press;
        req_c = MODE_R_TO_L;
        if (press[0]) begin
            req_c = MODE_CYLON;
        end else if (press[2]) begin
            req_c = MODE_L_TO_R;
        end
    end

    state_t         state, state_n;
    logic [1:0]     pend_mode, pend_mode_n;
    logic [1:0]     mode_n;
    logic [1:0]     apply_val;
    logic [TOW-1:0] to_cnt, to_cnt_n;
    logic           mode_changed_n;

    // Next-state and next-output logic
    always_comb begin
        state_n        = state;
        mode_n         = mode;
        pend_mode_n    = pend_mode;
        to_cnt_n       = to_cnt;
        mode_changed_n = 1'b0;
        apply_val      = pend_mode;
        case (state)
            ST_RUN: begin
                if (ev_c && (req_c != mode)) begin
                    pend_mode_n = req_c;
                    to_cnt_n    = '0;
                    state_n     = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // Latest request wins and restarts the timeout
                if (ev_c) begin
                    apply_val   = req_c;
                    pend_mode_n = req_c;
                    to_cnt_n    = '0;
                end else if (to_cnt != TO_LAST) begin
                    to_cnt_n = to_cnt + TOW'(1);
                end
                if (step || (to_cnt == TO_LAST)) begin
                    mode_n         = apply_val;
                    mode_changed_n = (apply_val != mode);
                    state_n        = ST_RUN;
                end
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    // State and output registers; speed/brightness follow the switches on step only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            mode         <= MODE_CYLON;
            pend_mode    <= MODE_CYLON;
            to_cnt       <= '0;
            mode_changed <= 1'b0;
            pending      <= 1'b0;
            speed        <= 4'b0000;
            brightness   <= 4'b0111;
        end else begin
            state        <= state_n;
            mode         <= mode_n;
            pend_mode    <= pend_mode_n;
            to_cnt       <= to_cnt_n;
            mode_changed <= mode_changed_n;
            pending      <= (state_n == ST_PENDING);
            if (step) begin
                speed      <= {1'b0, sw_s2[2:0]};
                brightness <= {sw_s2[3], 3'b111};
            end
        end
    end

endmodule

// File: tb/tb_cylon_mode_ctrl.sv
// Directed, table-driven bench for cylon_mode_ctrl with DEBOUNCE_CYCLES=4,
// STEP_TIMEOUT=50. Each record holds inputs for N cycles, then compares all
// outputs one cycle-edge later. Async reset handled by a hand-written sequence.
module tb_cylon_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_c = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic [3:0] sw = 4'b0000;
    logic       step = 1'b0;
    logic [1:0] mode;
    logic [3:0] speed;
    logic [3:0] brightness;
    logic       pending;
    logic       mode_changed;

    int checks = 0;
    int errors = 0;

    cylon_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .STEP_TIMEOUT   (50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_c       (btn_c),
        .btn_l       (btn_l),
        .btn_r       (btn_r),
        .sw          (sw),
        .step        (step),
        .mode        (mode),
        .speed       (speed),
        .brightness  (brightness),
        .pending     (pending),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       c;
        logic       l;
        logic       r;
        logic [3:0] sw;
        logic       stp;
        int         reps;
        logic [11:0] exp;
    } vec_t;

    vec_t vq[$];

    // Expected output word: {mode, speed, brightness, pending, mode_changed}
    function automatic logic [11:0] pk(logic [1:0] m, logic [3:0] s, logic [3:0] b,
                                       logic p, logic mc);
        return {m, s, b, p, mc};
    endfunction

    function automatic void add(string nm, logic c, logic l, logic r, logic [3:0] s,
                                logic stp, int reps, logic [11:0] e);
        vec_t v;
        v.name = nm;
        v.c    = c;
        v.l    = l;
        v.r    = r;
        v.sw   = s;
        v.stp  = stp;
        v.reps = reps;
        v.exp  = e;
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [11:0] e);
        logic [11:0] a;
        a = {mode, speed, brightness, pending, mode_changed};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got mode=%b speed=%b bright=%b pending=%b mc=%b, want mode=%b speed=%b bright=%b pending=%b mc=%b",
                     nm, a[11:10], a[9:6], a[5:2], a[1], a[0],
                     e[11:10], e[9:6], e[5:2], e[1], e[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Clean right press, step long after: pending from cycle 7, applied at step
        add("r_db_wait",   0, 0, 1, 4'b0000, 0, 6,  pk(2'b00, 4'b0000, 4'b0111, 0, 0));
        add("r_pend",      0, 0, 1, 4'b0000, 0, 1,  pk(2'b00, 4'b0000, 4'b0111, 1, 0));
        add("r_hold",      0, 0, 1, 4'b0000, 0, 13, pk(2'b00, 4'b0000, 4'b0111, 1, 0));
        add("r_release",   0, 0, 0, 4'b0000, 0, 10, pk(2'b00, 4'b0000, 4'b0111, 1, 0));
        add("r_step",      0, 0, 0, 4'b0000, 1, 1,  pk(2'b10, 4'b0000, 4'b0111, 0, 1));
        add("r_after",     0, 0, 0, 4'b0000, 0, 1,  pk(2'b10, 4'b0000, 4'b0111, 0, 0));
        // Left button bouncing every 2 cycles: never accepted
        for (int i = 0; i < 5; i++) begin
            add("l_bounce_hi", 0, 1, 0, 4'b0000, 0, 2, pk(2'b10, 4'b0000, 4'b0111, 0, 0));
            add("l_bounce_lo", 0, 0, 0, 4'b0000, 0, 2, pk(2'b10, 4'b0000, 4'b0111, 0, 0));
        end
        add("l_bounce_end", 0, 0, 0, 4'b0000, 0, 10, pk(2'b10, 4'b0000, 4'b0111, 0, 0));
        // All three buttons together: centre wins
        add("all3_pend",   1, 1, 1, 4'b0000, 0, 7,  pk(2'b10, 4'b0000, 4'b0111, 1, 0));
        add("all3_release",0, 0, 0, 4'b0000, 0, 10, pk(2'b10, 4'b0000, 4'b0111, 1, 0));
        add("all3_step",   0, 0, 0, 4'b0000, 1, 1,  pk(2'b00, 4'b0000, 4'b0111, 0, 1));
        add("all3_after",  0, 0, 0, 4'b0000, 0, 1,  pk(2'b00, 4'b0000, 4'b0111, 0, 0));
        // Pending 01 overwritten by a right press before the step
        add("l_pend",      0, 1, 0, 4'b0000, 0, 7,  pk(2'b00, 4'b0000, 4'b0111, 1, 0));
        add("l_release",   0, 0, 0, 4'b0000, 0, 8,  pk(2'b00, 4'b0000, 4'b0111, 1, 0));
        add("r_overwrite", 0, 0, 1, 4'b0000, 0, 7,  pk(2'b00, 4'b0000, 4'b0111, 1, 0));
        add("r_release2",  0, 0, 0, 4'b0000, 0, 8,  pk(2'b00, 4'b0000, 4'b0111, 1, 0));
        add("over_step",   0, 0, 0, 4'b0000, 1, 1,  pk(2'b10, 4'b0000, 4'b0111, 0, 1));
        // Step coinciding with a centre event while pending: event value applied
        add("l_pend2",     0, 1, 0, 4'b0000, 0, 7,  pk(2'b10, 4'b0000, 4'b0111, 1, 0));
        add("l_release3",  0, 0, 0, 4'b0000, 0, 8,  pk(2'b10, 4'b0000, 4'b0111, 1, 0));
        add("c_wait",      1, 0, 0, 4'b0000, 0, 6,  pk(2'b10, 4'b0000, 4'b0111, 1, 0));
        add("c_step_same", 1, 0, 0, 4'b0000, 1, 1,  pk(2'b00, 4'b0000, 4'b0111, 0, 1));
        add("c_release",   0, 0, 0, 4'b0000, 0, 8,  pk(2'b00, 4'b0000, 4'b0111, 0, 0));
        // Step with event in RUN enters PENDING; no further step, timeout forces
        add("l_run_wait",  0, 1, 0, 4'b0000, 0, 6,  pk(2'b00, 4'b0000, 4'b0111, 0, 0));
        add("l_run_step",  0, 1, 0, 4'b0000, 1, 1,  pk(2'b00, 4'b0000, 4'b0111, 1, 0));
        add("tmo_wait",    0, 0, 0, 4'b0101, 0, 49, pk(2'b00, 4'b0000, 4'b0111, 1, 0));
        add("tmo_fire",    0, 0, 0, 4'b0101, 0, 1,  pk(2'b01, 4'b0000, 4'b0111, 0, 1));
        add("tmo_after",   0, 0, 0, 4'b0101, 0, 1,  pk(2'b01, 4'b0000, 4'b0111, 0, 0));
        // Switches only sampled on step
        add("sw_hold",     0, 0, 0, 4'b1011, 0, 5,  pk(2'b01, 4'b0000, 4'b0111, 0, 0));
        add("sw_step",     0, 0, 0, 4'b1011, 1, 1,  pk(2'b01, 4'b0011, 4'b1111, 0, 0));

        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_state", pk(2'b00, 4'b0000, 4'b0111, 0, 0));
        rst_n = 1'b1;

        foreach (vq[i]) begin
            btn_c = vq[i].c;
            btn_l = vq[i].l;
            btn_r = vq[i].r;
            sw    = vq[i].sw;
            step  = vq[i].stp;
            repeat (vq[i].reps) tick();
            check(vq[i].name, vq[i].exp);
        end
        step = 1'b0;

        // Asynchronous reset while a centre request is pending
        btn_c = 1'b1;
        repeat (7) tick();
        check("c_pend_pre_rst", pk(2'b01, 4'b0011, 4'b1111, 1, 0));
        btn_c = 1'b0;
        repeat (3) tick();
        check("c_pend_hold", pk(2'b01, 4'b0011, 4'b1111, 1, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", pk(2'b00, 4'b0000, 4'b0111, 0, 0));
        repeat (2) tick();
        check("rst_held", pk(2'b00, 4'b0000, 4'b0111, 0, 0));
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_idle", pk(2'b00, 4'b0000, 4'b0111, 0, 0));
        step = 1'b1;
        tick();
        step = 1'b0;
        check("post_rst_step", pk(2'b00, 4'b0011, 4'b1111, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cylon_mode_ctrl.md
Name: cylon_mode_ctrl

Overview:
- Control front-end for the cylon LED engine. It sits between the board buttons/switches and the engine's mode/speed/brightness inputs.
- Synchronises and debounces the three buttons, arbitrates simultaneous presses, and holds a requested mode change pending until the engine reports a step boundary. This prevents the pattern from jumping mid-step.
- Samples the switches into speed and brightness on the same step boundaries.
- Includes a timeout so that a stalled engine cannot block mode changes indefinitely.

Parameters:
- DEBOUNCE_CYCLES, 20'd1_000_000: consecutive stable cycles required before a synchronised button level is accepted (min 2).
- STEP_TIMEOUT, 29'd100_000_000: cycles in PENDING with no step pulse before the pending mode is forced (min 1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_c  input  1  raw centre button, request MODE_CYLON (00)
- btn_l  input  1  raw left button, request MODE_R_TO_L (01)
- btn_r  input  1  raw right button, request MODE_L_TO_R (10)
- sw  input  4  raw switches; sw[2:0] speed, sw[3] brightness MSB
- step  input  1  one-cycle pulse from the engine at each LED position change
- mode  output  2  mode to engine
- speed  output  4  speed multiplier to engine, {1'b0, sw[2:0]}
- brightness  output  4  brightness to engine, {sw[3], 3'b111}
- pending  output  1  high while a mode change is waiting for a step boundary
- mode_changed  output  1  one-cycle pulse in the cycle mode takes a new value

Behaviour:

Reset (async assert, sync release):
- mode=00, speed=0000, brightness=0111, pending=0, mode_changed=0, state=RUN.
- All synchroniser, debounce and timeout state cleared to 0.

Input path:
- btn_c/l/r and sw[3:0] each pass through a 2-flop synchroniser.
- Each button has a debounce counter. While the synchronised level differs from the debounced level, the counter increments; it clears whenever they are equal.
- When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- A press event is a 1-cycle pulse on a debounced 0->1 transition. Releases generate no event.
- Latency: with the raw input held stable high from cycle 0, the press event occurs in cycle DEBOUNCE_CYCLES+2.
- A bounce shorter than DEBOUNCE_CYCLES cycles produces no event.

Arbitration:
- Events in the same cycle resolve by priority C > R > L. The winner is the requested mode (req).

FSM:
- RUN:
  - event with req != mode -> pend_mode=req, timeout counter cleared, go to PENDING.
  - event with req == mode -> ignored.
- PENDING:
  - new event -> pend_mode overwritten (latest wins), timeout counter cleared.
  - Otherwise the timeout counter increments.
  - step, or timeout counter reaching STEP_TIMEOUT-1 -> mode <= pend_mode (or req if an event occurs in that same cycle), mode_changed=1 in that cycle, go to RUN.
  - If the applied value equals the current mode, there is no mode_changed pulse; still go to RUN.
- Same-cycle step and event while in RUN: the event enters PENDING and is applied at the following step, not the current one.
- pending is 1 exactly while state==PENDING (registered, no combinational path).

Speed/brightness:
- On every step pulse, in either state, speed <= {1'b0, sw_sync[2:0]} and brightness <= {sw_sync[3], 3'b111}.
- With no step pulses they hold their values, and they do not update on timeout.

Counter widths:
- Sized to their parameters. The timeout counter saturates and never wraps.

Mid-operation reset:
- Assertion in PENDING discards pend_mode. Outputs return to reset values immediately, with no mode_changed pulse.

Test Plan (DEBOUNCE_CYCLES=4, STEP_TIMEOUT=50):
- Clean btn_r press, held 20 cycles, step at cycle 30 -> pending=1 from cycle 7; mode 00->10 and mode_changed=1 exactly in the step cycle; pending=0 the next cycle.
- btn_l toggles 1/0 every 2 cycles for 20 cycles, then 0 -> no press event, mode and pending unchanged throughout.
- btn_c, btn_l, btn_r rise in the same cycle while mode=10 -> req=00 (C wins); applied at next step; mode_changed pulses once.
- In PENDING (pend 01), press btn_r before the step -> at the step mode=10, not 01. Second case: step and a new btn_c event in the same PENDING cycle -> mode=00 that cycle.
- btn_l press with no step for 60 cycles -> mode=01 forced in cycle 50 after entry to PENDING; mode_changed=1; speed/brightness unchanged.
- sw=4'b1011 applied with no step -> speed/brightness hold reset values. At the next step -> speed=0011, brightness=1111. Then rst_n low mid-PENDING -> mode=00, pending=0, brightness=0111 immediately.
